// File: rtl/force_release_pkg.sv
// Shared types, constants and the channel-slicing helper for the force/release overlay.
package force_release_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        FORCED = 1'b1
    } ch_state_t;

    localparam int CNT_W       = 16;
    // Widest concatenated per-channel vector supported (16 channels x 64 bits).
    localparam int SLICE_VEC_W = 1024;

    function automatic logic [SLICE_VEC_W-1:0] slice_of(input logic [SLICE_VEC_W-1:0] vec,
                                                        input int c, input int w);
        return vec >> (c * w);
    endfunction

endpackage

// File: rtl/force_release_ch.sv
// One force channel: enable edge detect, IDLE/FORCED state, mask/value capture.
// With FORCE_RELEASE_CTRL_AUDIT_EN defined it also counts IDLE->FORCED entries.
module force_release_ch
    import force_release_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_mask,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_active,
    output logic [WIDTH-1:0] o_mask,
    output logic [WIDTH-1:0] o_value
`ifdef FORCE_RELEASE_CTRL_AUDIT_EN
    ,
    output logic [CNT_W-1:0] o_cnt
`endif
);

    logic             en_q_r;
    ch_state_t        state_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] value_r;
    logic             rise_s;
    logic             fall_s;
`ifdef FORCE_RELEASE_CTRL_AUDIT_EN
    logic [CNT_W-1:0] cnt_r;
`endif

    assign rise_s = i_en & ~en_q_r;
    assign fall_s = ~i_en & en_q_r;

    // Channel state, capture registers and enable history.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q_r  <= 1'b0;
            state_r <= IDLE;
            mask_r  <= {WIDTH{1'b0}};
            value_r <= {WIDTH{1'b0}};
`ifdef FORCE_RELEASE_CTRL_AUDIT_EN
            cnt_r   <= {CNT_W{1'b0}};
`endif
        end else begin
            en_q_r <= i_en;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= FORCED;
                        mask_r  <= i_mask;
                        value_r <= i_value;
`ifdef FORCE_RELEASE_CTRL_AUDIT_EN
                        if (cnt_r != {CNT_W{1'b1}}) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
`endif
                    end
                end
                FORCED: begin
                    if (fall_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign o_active = (state_r == FORCED);
    assign o_mask   = mask_r;
    assign o_value  = value_r;
`ifdef FORCE_RELEASE_CTRL_AUDIT_EN
    assign o_cnt    = cnt_r;
`endif

endmodule

// File: rtl/force_release_ctrl.sv
// Multi-channel force/release overlay: priority merge, optional release hold, sticky conflict.
// Optional per-channel force counters are enabled by FORCE_RELEASE_CTRL_AUDIT_EN.
module force_release_ctrl
    import force_release_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_CH       = 4,
    parameter int RELEASE_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        i_data,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH*WIDTH-1:0] i_mask,
    input  logic [NUM_CH*WIDTH-1:0] i_value,
    output logic [WIDTH-1:0]        o_data,
    output logic [WIDTH-1:0]        o_forced,
    output logic [NUM_CH-1:0]       o_ch_active,
    output logic                    o_conflict
`ifdef FORCE_RELEASE_CTRL_AUDIT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] o_force_cnt
`endif
);

    logic [WIDTH-1:0]  ch_mask_s  [NUM_CH];
    logic [WIDTH-1:0]  ch_value_s [NUM_CH];
    logic [WIDTH-1:0]  cap_mask_s [NUM_CH];
    logic [WIDTH-1:0]  cap_value_s[NUM_CH];
    logic [NUM_CH-1:0] active_s;
    logic [WIDTH-1:0]  fset_s;
    logic              overlap_s;
    logic [WIDTH-1:0]  hold_s;
    logic [WIDTH-1:0]  hv_s;
    logic [WIDTH-1:0]  data_s;
    logic              conflict_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_mask_s[c]  = WIDTH'(slice_of(SLICE_VEC_W'(i_mask), c, WIDTH));
        assign ch_value_s[c] = WIDTH'(slice_of(SLICE_VEC_W'(i_value), c, WIDTH));

        force_release_ch #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_en     (i_en[c]),
            .i_mask   (ch_mask_s[c]),
            .i_value  (ch_value_s[c]),
            .o_active (active_s[c]),
            .o_mask   (cap_mask_s[c]),
            .o_value  (cap_value_s[c])
`ifdef FORCE_RELEASE_CTRL_AUDIT_EN
            ,
            .o_cnt    (o_force_cnt[c*CNT_W +: CNT_W])
`endif
        );
    end

    // Union of active masks and pairwise-overlap detection.
    always_comb begin
        fset_s    = {WIDTH{1'b0}};
        overlap_s = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (active_s[c]) begin
                overlap_s = overlap_s | (|(fset_s & cap_mask_s[c]));
                fset_s    = fset_s | cap_mask_s[c];
            end else begin
                fset_s    = fset_s;
            end
        end
    end

    if (RELEASE_HOLD != 0) begin : g_hold
        logic [WIDTH-1:0] hold_r, held_val_r, rec_r, fq_r, dq_r, iq_r, rel_s, rec_s;

        // Bits that were forced last cycle and are no longer forced now.
        assign rel_s  = fq_r & ~fset_s;
        assign hv_s   = (rel_s & dq_r) | (~rel_s & held_val_r);
        assign rec_s  = (rel_s & iq_r) | (~rel_s & rec_r);
        assign hold_s = (rel_s | hold_r) & ~(i_data ^ rec_s) & ~fset_s;

        // Hold state plus last-cycle forced set, output and input.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_r     <= {WIDTH{1'b0}};
                held_val_r <= {WIDTH{1'b0}};
                rec_r      <= {WIDTH{1'b0}};
                fq_r       <= {WIDTH{1'b0}};
                dq_r       <= {WIDTH{1'b0}};
                iq_r       <= {WIDTH{1'b0}};
            end else begin
                hold_r     <= hold_s;
                held_val_r <= hv_s;
                rec_r      <= rec_s;
                fq_r       <= fset_s;
                dq_r       <= data_s;
                iq_r       <= i_data;
            end
        end
    end else begin : g_net
        assign hold_s = {WIDTH{1'b0}};
        assign hv_s   = {WIDTH{1'b0}};
    end

    // Priority merge: later (higher-index) channels override earlier ones.
    always_comb begin
        data_s = (hold_s & hv_s) | (~hold_s & i_data);
        for (int c = 0; c < NUM_CH; c++) begin
            if (active_s[c]) begin
                data_s = (data_s & ~cap_mask_s[c]) | (cap_value_s[c] & cap_mask_s[c]);
            end else begin
                data_s = data_s;
            end
        end
    end

    // Sticky overlap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_r <= 1'b0;
        end else begin
            conflict_r <= conflict_r | overlap_s;
        end
    end

    assign o_data      = data_s;
    assign o_forced    = fset_s | hold_s;
    assign o_ch_active = active_s;
    assign o_conflict  = conflict_r;

endmodule
